// File: rtl/mmio_periph_slave.sv
// Memory-mapped peripheral slave: GPIO out/in, prescaled down-counting timer with IRQ.
// Optional PWM compare output is enabled by defining PERIPH_PWM_EN.
module mmio_periph_slave #(
  parameter int GPIO_W  = 16,
  parameter int PRESC_W = 16,
  parameter int OFFS_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m_sel,
  input  logic              m_rnw,
  input  logic [31:0]       m_addr,
  input  logic [31:0]       m_data,
  output logic [31:0]       s_data,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [GPIO_W-1:0] gpio_out,
  output logic              irq,
  output logic              pwm_out
);

  localparam int IDX_W = OFFS_W - 2;
  localparam logic [IDX_W-1:0] A_GPIO_OUT = IDX_W'(0);
  localparam logic [IDX_W-1:0] A_GPIO_IN  = IDX_W'(1);
  localparam logic [IDX_W-1:0] A_CTRL     = IDX_W'(2);
  localparam logic [IDX_W-1:0] A_LOAD     = IDX_W'(3);
  localparam logic [IDX_W-1:0] A_COUNT    = IDX_W'(4);
  localparam logic [IDX_W-1:0] A_STATUS   = IDX_W'(5);
  localparam logic [IDX_W-1:0] A_PRESC    = IDX_W'(6);
  localparam logic [IDX_W-1:0] A_PWM_CMP  = IDX_W'(7);

  logic [GPIO_W-1:0]  gpio_out_q, gpio_out_d;
  logic [GPIO_W-1:0]  sync1_q, sync2_q;
  logic [2:0]         ctrl_q, ctrl_d;
  logic [31:0]        load_q, load_d;
  logic [31:0]        count_q, count_d;
  logic               expired_q, expired_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [PRESC_W-1:0] pcnt_q, pcnt_d;
  logic               irq_q, irq_d;

  logic [IDX_W-1:0]   idx_s;
  logic               wr_s;
  logic               tick_s;
  logic               unused_s;

  assign idx_s    = m_addr[OFFS_W-1:2];
  assign wr_s     = m_sel & ~m_rnw;
  assign tick_s   = ctrl_q[0] & (pcnt_q == presc_q);
  assign unused_s = ^{m_addr[31:OFFS_W], m_addr[1:0]};

`ifdef PERIPH_PWM_EN
  logic [31:0] pwm_cmp_q, pwm_cmp_d;
  logic        pwm_q, pwm_d;
`endif

  // Next-state for GPIO, timer, status and interrupt registers
  always_comb begin
    gpio_out_d = gpio_out_q;
    ctrl_d     = ctrl_q;
    load_d     = load_q;
    count_d    = count_q;
    expired_d  = expired_q;
    presc_d    = presc_q;
    pcnt_d     = '0;
    irq_d      = expired_q & ctrl_q[2];

    if (ctrl_q[0] && !tick_s) begin
      pcnt_d = pcnt_q + PRESC_W'(1);
    end else begin
      pcnt_d = '0;
    end

    // Tick uses the pre-write CTRL; register writes below override its effects
    if (tick_s) begin
      if (count_q == 32'd0) begin
        if (ctrl_q[1]) begin
          count_d = load_q;
        end else begin
          ctrl_d[0] = 1'b0;
        end
      end else begin
        count_d = count_q - 32'd1;
      end
    end else begin
      count_d = count_q;
    end

    if (wr_s) begin
      case (idx_s)
        A_GPIO_OUT: gpio_out_d = m_data[GPIO_W-1:0];
        A_CTRL:     ctrl_d     = m_data[2:0];
        A_LOAD: begin
          load_d  = m_data;
          count_d = m_data;
          pcnt_d  = '0;
        end
        A_STATUS: begin
          if (m_data[0]) begin
            expired_d = 1'b0;
          end else begin
            expired_d = expired_q;
          end
        end
        A_PRESC:    presc_d = m_data[PRESC_W-1:0];
        default:    ;
      endcase
    end else begin
      gpio_out_d = gpio_out_q;
    end

    if (tick_s && (count_q == 32'd0)) begin
      expired_d = 1'b1;
    end else begin
      expired_d = expired_d;
    end
  end

`ifdef PERIPH_PWM_EN
  // PWM compare register and registered compare output
  always_comb begin
    pwm_cmp_d = pwm_cmp_q;
    if (wr_s && (idx_s == A_PWM_CMP)) begin
      pwm_cmp_d = m_data;
    end else begin
      pwm_cmp_d = pwm_cmp_q;
    end
    pwm_d = ctrl_q[0] & (count_q < pwm_cmp_q);
  end

  // PWM state flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cmp_q <= 32'd0;
      pwm_q     <= 1'b0;
    end else begin
      pwm_cmp_q <= pwm_cmp_d;
      pwm_q     <= pwm_d;
    end
  end

  assign pwm_out = pwm_q;
`else
  assign pwm_out = 1'b0;
`endif

  // Main register bank and GPIO input synchroniser
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gpio_out_q <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      ctrl_q     <= 3'd0;
      load_q     <= 32'd0;
      count_q    <= 32'd0;
      expired_q  <= 1'b0;
      presc_q    <= '0;
      pcnt_q     <= '0;
      irq_q      <= 1'b0;
    end else begin
      gpio_out_q <= gpio_out_d;
      sync1_q    <= gpio_in;
      sync2_q    <= sync1_q;
      ctrl_q     <= ctrl_d;
      load_q     <= load_d;
      count_q    <= count_d;
      expired_q  <= expired_d;
      presc_q    <= presc_d;
      pcnt_q     <= pcnt_d;
      irq_q      <= irq_d;
    end
  end

  // Combinational read mux so the M/WB register captures data in the access cycle
  always_comb begin
    s_data = 32'd0;
    if (m_sel) begin
      case (idx_s)
        A_GPIO_OUT: s_data = 32'(gpio_out_q);
        A_GPIO_IN:  s_data = 32'(sync2_q);
        A_CTRL:     s_data = {29'd0, ctrl_q};
        A_LOAD:     s_data = load_q;
        A_COUNT:    s_data = count_q;
        A_STATUS:   s_data = {31'd0, expired_q};
        A_PRESC:    s_data = 32'(presc_q);
`ifdef PERIPH_PWM_EN
        A_PWM_CMP:  s_data = pwm_cmp_q;
`endif
        default:    s_data = 32'd0;
      endcase
    end else begin
      s_data = 32'd0;
    end
  end

  assign gpio_out = gpio_out_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_mmio_periph_slave.sv
// Self-checking bench for mmio_periph_slave: directed steps plus random accesses vs. a cycle model.
module tb_mmio_periph_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic        m_sel, m_rnw;
  logic [31:0] m_addr, m_data;
  logic [31:0] s_data;
  logic [15:0] gpio_in;
  logic [15:0] gpio_out;
  logic        irq, pwm_out;

  int errors = 0;
  int checks = 0;
  logic [31:0] last_rd;

  // Reference model state, named after the register map
  logic [15:0] md_gpo, md_s1, md_s2, md_presc, md_pcnt;
  logic        md_en, md_ar, md_ie, md_exp, md_irq, md_pwm;
  logic [31:0] md_load, md_count, md_cmp;

  mmio_periph_slave dut (
    .clk(clk), .rst(rst), .m_sel(m_sel), .m_rnw(m_rnw), .m_addr(m_addr),
    .m_data(m_data), .s_data(s_data), .gpio_in(gpio_in), .gpio_out(gpio_out),
    .irq(irq), .pwm_out(pwm_out)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    md_gpo = '0; md_s1 = '0; md_s2 = '0; md_presc = '0; md_pcnt = '0;
    md_en = 0; md_ar = 0; md_ie = 0; md_exp = 0; md_irq = 0; md_pwm = 0;
    md_load = '0; md_count = '0; md_cmp = '0;
  endtask

  function automatic logic [31:0] model_read(input logic sel, input logic [31:0] a);
    if (!sel) return 32'd0;
    case (a[7:2])
      6'd0: return {16'd0, md_gpo};
      6'd1: return {16'd0, md_s2};
      6'd2: return {29'd0, md_ie, md_ar, md_en};
      6'd3: return md_load;
      6'd4: return md_count;
      6'd5: return {31'd0, md_exp};
      6'd6: return {16'd0, md_presc};
`ifdef PERIPH_PWM_EN
      6'd7: return md_cmp;
`endif
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic model_expires_now();
    return md_en && (md_pcnt == md_presc) && (md_count == 32'd0);
  endfunction

  // Advance the model over one clock edge from the current inputs
  task automatic cycle();
    logic wr, tick;
    logic [15:0] n_gpo, n_presc, n_pcnt;
    logic        n_en, n_ar, n_ie, n_exp, n_irq, n_pwm;
    logic [31:0] n_load, n_count, n_cmp;
    wr = m_sel && !m_rnw;
    tick = md_en && (md_pcnt == md_presc);
    n_gpo = md_gpo; n_presc = md_presc; n_en = md_en; n_ar = md_ar; n_ie = md_ie;
    n_exp = md_exp; n_load = md_load; n_count = md_count; n_cmp = md_cmp;
    n_pcnt = md_en ? (tick ? 16'd0 : md_pcnt + 16'd1) : 16'd0;
    if (tick) begin
      if (md_count == 32'd0) begin
        n_exp = 1'b1;
        if (md_ar) n_count = md_load; else n_en = 1'b0;
      end else begin
        n_count = md_count - 32'd1;
      end
    end
    if (wr) begin
      case (m_addr[7:2])
        6'd0: n_gpo = m_data[15:0];
        6'd2: {n_ie, n_ar, n_en} = m_data[2:0];
        6'd3: begin n_load = m_data; n_count = m_data; n_pcnt = 16'd0; end
        6'd5: if (m_data[0] && !(tick && md_count == 32'd0)) n_exp = 1'b0;
        6'd6: n_presc = m_data[15:0];
`ifdef PERIPH_PWM_EN
        6'd7: n_cmp = m_data;
`endif
        default: ;
      endcase
    end
    n_irq = md_exp && md_ie;
`ifdef PERIPH_PWM_EN
    n_pwm = md_en && (md_count < md_cmp);
`else
    n_pwm = 1'b0;
`endif
    @(posedge clk);
    #1;
    md_s2 = md_s1; md_s1 = gpio_in;
    md_gpo = n_gpo; md_presc = n_presc; md_pcnt = n_pcnt; md_en = n_en; md_ar = n_ar;
    md_ie = n_ie; md_exp = n_exp; md_irq = n_irq; md_pwm = n_pwm;
    md_load = n_load; md_count = n_count; md_cmp = n_cmp;
  endtask

  // Drive one bus cycle, check all outputs against the model, then clock it
  task automatic access(input logic sel, input logic rnw, input logic [31:0] addr,
                        input logic [31:0] data);
    m_sel = sel; m_rnw = rnw; m_addr = addr; m_data = data;
    #1;
    last_rd = s_data;
    chk("s_data", s_data, model_read(sel, addr));
    chk("gpio_out", {16'd0, gpio_out}, {16'd0, md_gpo});
    chk("irq", {31'd0, irq}, {31'd0, md_irq});
    chk("pwm_out", {31'd0, pwm_out}, {31'd0, md_pwm});
    cycle();
  endtask

  task automatic wr32(input logic [31:0] addr, input logic [31:0] data);
    access(1'b1, 1'b0, addr, data);
  endtask

  task automatic rd32(input logic [31:0] addr);
    access(1'b1, 1'b1, addr, 32'd0);
  endtask

  initial begin
    int rises[$];
    int t;
    int hi;
    logic prev;
    logic found;
    rst = 1'b1; m_sel = 0; m_rnw = 1; m_addr = '0; m_data = '0; gpio_in = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gpio_out", {16'd0, gpio_out}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    rst = 1'b0;

    // Mid-operation reset with EN=1 and COUNT=5
    wr32(32'h00, 32'h0000_1234);
    wr32(32'h18, 32'h0000_FFFF);
    wr32(32'h0C, 32'd5);
    wr32(32'h08, 32'd7);
    rd32(32'h10);
    chk("pre_rst_count", last_rd, 32'd5);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_gpio_out", {16'd0, gpio_out}, 32'd0);
    chk("async_rst_irq", {31'd0, irq}, 32'd0);
    chk("async_rst_pwm", {31'd0, pwm_out}, 32'd0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    rd32(32'h08); chk("post_rst_ctrl", last_rd, 32'd0);
    rd32(32'h0C); chk("post_rst_load", last_rd, 32'd0);
    rd32(32'h10); chk("post_rst_count", last_rd, 32'd0);

    // GPIO output width truncation and unmapped read
    wr32(32'h00, 32'hFFFF_A5A5);
    chk("gpio_out_a5a5", {16'd0, gpio_out}, 32'h0000_A5A5);
    rd32(32'h00); chk("rd_gpio_out", last_rd, 32'h0000_A5A5);
    rd32(32'h20); chk("rd_unmapped_20", last_rd, 32'd0);

    // GPIO input two-stage synchroniser latency
    gpio_in = 16'h0F0F;
    rd32(32'h04); chk("gpin_N", last_rd, 32'd0);
    rd32(32'h04); chk("gpin_N1", last_rd, 32'd0);
    rd32(32'h04); chk("gpin_N2", last_rd, 32'h0000_0F0F);

    // Auto-reload period: LOAD=3, PRESC=1 -> 8 cycles per expiry
    wr32(32'h0C, 32'd3);
    wr32(32'h18, 32'd1);
    wr32(32'h08, 32'd7);
    prev = 1'b0;
    for (int c = 0; c < 40; c++) begin
      rd32(32'h14);
      if (last_rd[0] && !prev) begin
        rises.push_back(c);
        wr32(32'h14, 32'd1);
        c++;
        chk("irq_after_expiry", {31'd0, irq}, 32'd1);
        prev = 1'b0;
      end else begin
        prev = last_rd[0];
      end
    end
    chk("period_rise_count_ge3", {31'd0, rises.size() >= 3}, 32'd1);
    for (int i = 1; i < rises.size(); i++)
      chk("period_8", rises[i] - rises[i-1], 32'd8);
    access(1'b0, 1'b1, 32'h0, 32'h0);
    access(1'b0, 1'b1, 32'h0, 32'h0);

    // One-shot with W1C on the expiry cycle
    wr32(32'h08, 32'd0);
    wr32(32'h14, 32'd1);
    wr32(32'h0C, 32'd2);
    wr32(32'h18, 32'd0);
    wr32(32'h08, 32'd1);
    found = 1'b0;
    t = 0;
    while (!found && t < 20) begin
      if (model_expires_now()) begin
        chk("oneshot_ticks", t, 32'd2);
        wr32(32'h14, 32'd1);
        found = 1'b1;
      end else begin
        rd32(32'h10);
      end
      t++;
    end
    chk("oneshot_found", {31'd0, found}, 32'd1);
    rd32(32'h14); chk("oneshot_expired_set_wins", last_rd, 32'd1);
    rd32(32'h08); chk("oneshot_en_cleared", last_rd, 32'd0);
    rd32(32'h10); chk("oneshot_count0", last_rd, 32'd0);

    // PWM compare output
    wr32(32'h14, 32'd1);
    wr32(32'h1C, 32'd3);
    wr32(32'h0C, 32'd9);
    wr32(32'h18, 32'd0);
    wr32(32'h08, 32'd3);
    repeat (5) access(1'b0, 1'b1, 32'h0, 32'h0);
    hi = 0;
    for (int c = 0; c < 20; c++) begin
      if (pwm_out) hi++;
      access(1'b0, 1'b1, 32'h0, 32'h0);
    end
`ifdef PERIPH_PWM_EN
    chk("pwm_duty_6_of_20", hi, 32'd6);
    rd32(32'h1C); chk("pwm_cmp_rd", last_rd, 32'd3);
`else
    chk("pwm_off_duty", hi, 32'd0);
    rd32(32'h1C); chk("pwm_cmp_unmapped", last_rd, 32'd0);
`endif
    wr32(32'h08, 32'd0);

    // Randomized accesses against the model
    for (int c = 0; c < 600; c++) begin
      logic [31:0] a, d;
      a = ($urandom & 32'hFFFF_FF00) | (32'($urandom_range(0, 9)) << 2) | 32'($urandom_range(0, 3));
      d = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 12)) : $urandom;
      if ($urandom_range(0, 7) == 0) gpio_in = 16'($urandom);
      access($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), a, d);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
